piccolo_seq_ctrl: RTL and testbench

Sequencer and two-port arbiter for the iterative Piccolo-80/128 round datapath. It accepts encryption requests from two requesters and grants one per operation using round-robin. It sequences the datapath through load and round steps, sizing the final step to the selected version, and returns completion with the requester ID. Data, key and ciphertext muxing stay outside the block, steered by `core_sel`.

---
 rtl/piccolo_seq_ctrl_pkg.sv | 8 +
 rtl/piccolo_seq_ctrl_if.sv | 27 ++
 rtl/piccolo_rr_arb.sv | 8 +
 rtl/piccolo_seq_ctrl.sv | 55 +++++
 tb/tb_piccolo_seq_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/piccolo_seq_ctrl_pkg.sv
// piccolo_pkg: round counts, round-index width and sequencer state encoding
// shared by the Piccolo sequencer, its arbiter and its bus interface.
package piccolo_pkg;
   localparam int ROUNDS_80 = 25;
   localparam int ROUNDS_128 = 31;
   localparam int RND_W = 5;
   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/piccolo_seq_ctrl_if.sv
// piccolo_seq_ctrl_if: request, datapath-control and response signals of the sequencer.
interface piccolo_seq_ctrl_if;
   import piccolo_pkg::*;
   logic [1:0] req_valid;
   logic [1:0] req_version;
   logic [1:0] req_ready;
   logic core_load;
   logic core_sel;
   logic core_version;
   logic core_step;
   logic [RND_W-1:0] core_rnd;
   logic [RND_W-1:0] core_nrnd;
   logic rsp_valid;
   logic rsp_id;
   logic rsp_ready;
   logic busy;
   modport master (
      output req_valid, req_version, rsp_ready,
      input req_ready, core_load, core_sel, core_version, core_step, core_rnd, core_nrnd,
      input rsp_valid, rsp_id, busy
   );
   modport slave (
      input req_valid, req_version, rsp_ready,
      output req_ready, core_load, core_sel, core_version, core_step, core_rnd, core_nrnd,
      output rsp_valid, rsp_id, busy
   );
endinterface

// File: rtl/piccolo_rr_arb.sv
// piccolo_rr_arb: combinational 2-way round-robin arbiter; prio names the winner on contention.
module piccolo_rr_arb (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);
   assign gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/piccolo_seq_ctrl.sv
// piccolo_seq_ctrl: arbitrates two Piccolo requesters and steps the iterative
// round datapath through RPC-round steps, sizing the last step to the version.
module piccolo_seq_ctrl
   import piccolo_pkg::*;
#(
   parameter int RPC = 11
) (
   input logic clk,
   input logic reset,
   piccolo_seq_ctrl_if.slave bus
);
   localparam logic [5:0] RPC6 = 6'(RPC);
   seq_state_t state;
   logic prio, id_q, ver_q, g, grant, run, done;
   logic [1:0] gnt;
   logic [5:0] rcnt, n, rem, nrnd;
   piccolo_rr_arb u_arb (.req(bus.req_valid), .prio(prio), .gnt(gnt));
   assign grant = state == IDLE && !reset && |gnt;
   assign run = state == RUN && !reset;
   assign done = state == DONE && !reset;
   assign g = gnt[1];
   assign n = ver_q ? 6'(ROUNDS_128) : 6'(ROUNDS_80);
   assign rem = n - rcnt;
   assign nrnd = rem < RPC6 ? rem : RPC6;
   // Grant-cycle outputs come straight from the arbiter; afterwards from the latches.
   assign bus.req_ready = grant ? gnt : 2'b00;
   assign bus.core_load = grant;
   assign bus.core_sel = grant ? g : id_q;
   assign bus.core_version = grant ? bus.req_version[g] : ver_q;
   assign bus.core_step = run;
   assign bus.core_rnd = run ? rcnt[RND_W-1:0] : '0;
   assign bus.core_nrnd = run ? nrnd[RND_W-1:0] : '0;
   assign bus.rsp_valid = done;
   assign bus.rsp_id = id_q;
   assign bus.busy = state != IDLE && !reset;
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         prio <= 1'b0;
         rcnt <= '0;
         id_q <= 1'b0;
         ver_q <= 1'b0;
      end else if (grant) begin
         state <= RUN;
         rcnt <= '0;
         id_q <= g;
         ver_q <= bus.req_version[g];
      end else if (run) begin
         rcnt <= rcnt + nrnd;
         if (rcnt + nrnd == n) state <= DONE;
      end else if (done && bus.rsp_ready) begin
         prio <= ~id_q;
         state <= IDLE;
      end
endmodule

// File: tb/tb_piccolo_seq_ctrl.sv
// tb_piccolo_seq_ctrl: directed vector table for RPC=11 plus hand-written
// sequences for stall, mid-run reset, alternating grants and RPC=1 stepping.
module tb_piccolo_seq_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int ncmp = 0;
   int nfail = 0;
   always #5 clk = ~clk;
   piccolo_seq_ctrl_if i0 ();
   piccolo_seq_ctrl_if i1 ();
   piccolo_seq_ctrl #(.RPC(11)) d0 (.clk(clk), .reset(reset), .bus(i0));
   piccolo_seq_ctrl #(.RPC(1)) d1 (.clk(clk), .reset(reset), .bus(i1));
   typedef struct {
      logic [1:0] rv, rver;
      logic rrdy;
      logic [1:0] rdy;
      logic ld, sel, ver, stp;
      logic [4:0] rnd, nrnd;
      logic rsv, rid, bsy;
   } vec_t;
   vec_t tv[18];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int w, ng;
      int gt[4];
      int gc[4];
      // rv rver rrdy | rdy ld sel ver stp rnd nrnd rsv rid bsy
      tv[0]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
      tv[1]  = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
      tv[2]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd11, 1'b0, 1'b0, 1'b1};
      tv[3]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 5'd11, 1'b0, 1'b0, 1'b1};
      tv[4]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd22, 5'd3,  1'b0, 1'b0, 1'b1};
      tv[5]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
      tv[6]  = '{2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
      tv[7]  = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  5'd11, 1'b0, 1'b1, 1'b1};
      tv[8]  = '{2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 5'd11, 1'b0, 1'b1, 1'b1};
      tv[9]  = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd22, 5'd9,  1'b0, 1'b1, 1'b1};
      tv[10] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1};
      tv[11] = '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0};
      tv[12] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  5'd11, 1'b0, 1'b0, 1'b1};
      tv[13] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 5'd11, 1'b0, 1'b0, 1'b1};
      tv[14] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd22, 5'd9,  1'b0, 1'b0, 1'b1};
      tv[15] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
      tv[16] = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
      tv[17] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
      i0.req_valid = 2'b11;
      i0.req_version = 2'b11;
      i0.rsp_ready = 1'b1;
      i1.req_valid = 2'b00;
      i1.req_version = 2'b00;
      i1.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", i0.req_ready, 0);
      chk("rst_load", i0.core_load, 0);
      chk("rst_step", i0.core_step, 0);
      chk("rst_rsp_valid", i0.rsp_valid, 0);
      chk("rst_busy", i0.busy, 0);
      chk("rst_sel", i0.core_sel, 0);
      chk("rst_ver", i0.core_version, 0);
      chk("rst_rsp_id", i0.rsp_id, 0);
      reset = 1'b0;
      for (int i = 0; i < 18; i++) begin
         i0.req_valid = tv[i].rv;
         i0.req_version = tv[i].rver;
         i0.rsp_ready = tv[i].rrdy;
         #1;
         chk($sformatf("row%0d_ready", i), i0.req_ready, tv[i].rdy);
         chk($sformatf("row%0d_load", i), i0.core_load, tv[i].ld);
         chk($sformatf("row%0d_sel", i), i0.core_sel, tv[i].sel);
         chk($sformatf("row%0d_ver", i), i0.core_version, tv[i].ver);
         chk($sformatf("row%0d_step", i), i0.core_step, tv[i].stp);
         chk($sformatf("row%0d_rnd", i), i0.core_rnd, tv[i].rnd);
         chk($sformatf("row%0d_nrnd", i), i0.core_nrnd, tv[i].nrnd);
         chk($sformatf("row%0d_rsp_valid", i), i0.rsp_valid, tv[i].rsv);
         chk($sformatf("row%0d_rsp_id", i), i0.rsp_id, tv[i].rid);
         chk($sformatf("row%0d_busy", i), i0.busy, tv[i].bsy);
         adv();
      end
      // stall in DONE with both requesters pending
      i0.req_valid = 2'b10;
      i0.req_version = 2'b00;
      i0.rsp_ready = 1'b0;
      #1;
      chk("stall_accept", i0.req_ready, 2);
      adv();
      i0.req_valid = 2'b11;
      w = 0;
      while (!i0.rsp_valid && w < 10) begin
         adv();
         w++;
      end
      chk("stall_latency", w, 3);
      for (int k = 0; k < 5; k++) begin
         chk("stall_rsp_valid", i0.rsp_valid, 1);
         chk("stall_rsp_id", i0.rsp_id, 1);
         chk("stall_ready", i0.req_ready, 0);
         adv();
      end
      i0.rsp_ready = 1'b1;
      #1;
      chk("stall_release", i0.rsp_valid, 1);
      adv();
      chk("stall_idle", i0.busy, 0);
      chk("stall_prio", i0.req_ready, 1);
      // complete one op from requester 0 so prio becomes 1, then reset mid-run
      i0.req_valid = 2'b01;
      adv();
      i0.req_valid = 2'b00;
      w = 0;
      while (!i0.rsp_valid && w < 10) begin
         adv();
         w++;
      end
      chk("pre_rst_done", i0.rsp_valid, 1);
      adv();
      i0.req_valid = 2'b11;
      #1;
      chk("pre_rst_prio1", i0.req_ready, 2);
      i0.req_valid = 2'b01;
      adv();
      i0.req_valid = 2'b00;
      adv();
      chk("mid_step2_rnd", i0.core_rnd, 11);
      reset = 1'b1;
      i0.req_valid = 2'b01;
      adv();
      chk("mid_rst_ready", i0.req_ready, 0);
      chk("mid_rst_step", i0.core_step, 0);
      chk("mid_rst_nrnd", i0.core_nrnd, 0);
      chk("mid_rst_rsp_valid", i0.rsp_valid, 0);
      chk("mid_rst_busy", i0.busy, 0);
      chk("mid_rst_sel", i0.core_sel, 0);
      chk("mid_rst_rsp_id", i0.rsp_id, 0);
      reset = 1'b0;
      i0.req_valid = 2'b00;
      #1;
      chk("post_rst_busy", i0.busy, 0);
      chk("post_rst_load", i0.core_load, 0);
      i0.req_valid = 2'b11;
      #1;
      chk("post_rst_prio0", i0.req_ready, 1);
      i0.req_valid = 2'b10;
      #1;
      chk("post_rst_req1", i0.req_ready, 2);
      adv();
      i0.req_valid = 2'b00;
      #1;
      chk("post_rst_run", i0.core_step, 1);
      chk("post_rst_sel", i0.core_sel, 1);
      // both requesters held valid from reset: grants alternate
      reset = 1'b1;
      adv();
      reset = 1'b0;
      i0.req_valid = 2'b11;
      i0.rsp_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         #1;
         if (i0.req_ready != 2'b00) begin
            chk("alt_not_busy", i0.busy, 0);
            gt[ng] = int'(i0.req_ready[1]);
            gc[ng] = c;
            ng++;
         end
         adv();
      end
      chk("alt_count", ng, 4);
      for (int k = 0; k < ng; k++) begin
         chk($sformatf("alt_gnt%0d", k), gt[k], k % 2);
         if (k > 0) chk($sformatf("alt_gap%0d", k), gc[k] - gc[k-1], 5);
      end
      i0.req_valid = 2'b00;
      // RPC=1, Piccolo-128: 31 single-round steps
      i1.req_valid = 2'b01;
      i1.req_version = 2'b01;
      #1;
      chk("r1_accept", i1.req_ready, 1);
      adv();
      i1.req_valid = 2'b00;
      for (int k = 0; k < 31; k++) begin
         chk($sformatf("r1_step%0d", k), i1.core_step, 1);
         chk($sformatf("r1_rnd%0d", k), i1.core_rnd, k);
         chk($sformatf("r1_nrnd%0d", k), i1.core_nrnd, 1);
         adv();
      end
      chk("r1_rsp_valid", i1.rsp_valid, 1);
      chk("r1_rsp_id", i1.rsp_id, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
